// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: a drop-in stand-in for the DDR3 controller's
// s_axi port. It is backed by a dual-port 64-bit word RAM and has independent
// read and write FSMs. Each direction allows one outstanding transaction.
module axi_mem_responder #(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 30,
   parameter int MEM_WORDS = 8192,
   parameter     INIT_FILE = ""
) (
   input  logic              mig_ui_clk,
   input  logic              mig_ui_rst,
   // write address
   input  logic [ID_W-1:0]   s_axi_awid,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic              s_axi_awlock,
   input  logic [3:0]        s_axi_awcache,
   input  logic [2:0]        s_axi_awprot,
   input  logic [3:0]        s_axi_awqos,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   // write data
   input  logic [63:0]       s_axi_wdata,
   input  logic [7:0]        s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   // write response
   output logic [ID_W-1:0]   s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   // read address
   input  logic [ID_W-1:0]   s_axi_arid,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [7:0]        s_axi_arlen,
   input  logic [2:0]        s_axi_arsize,
   input  logic [1:0]        s_axi_arburst,
   input  logic              s_axi_arlock,
   input  logic [3:0]        s_axi_arcache,
   input  logic [2:0]        s_axi_arprot,
   input  logic [3:0]        s_axi_arqos,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   // read data
   output logic [ID_W-1:0]   s_axi_rid,
   output logic [63:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rlast,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
   localparam logic [1:0]  OKAY      = 2'b00;
   localparam logic [1:0]  SLVERR    = 2'b10;
   localparam logic [1:0]  DECERR    = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

   // Next beat address. WRAP keeps the upper bits (window base) and lets the
   // low bits inside the (len+1)*step window roll over.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
         input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] ln);
      logic [ADDR_W-1:0] step, mask, nxt;
      step = ADDR_W'(1) << sz;
      mask = ((ADDR_W'(ln) + ADDR_W'(1)) << sz) - ADDR_W'(1);
      case (bu)
         2'b00:   nxt = a;
         2'b10:   nxt = (a & ~mask) | ((a + step) & mask);
         default: nxt = a + step;
      endcase
      return nxt;
   endfunction

   // Request shapes the responder refuses with SLVERR.
   function automatic logic cfg_err(input logic [2:0] sz, input logic [1:0] bu,
         input logic [7:0] ln);
      return (sz > 3'd3) || (bu == 2'b11) ||
             ((bu == 2'b10) && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15));
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {{(64-ADDR_W){1'b0}}, a} < MEM_BYTES;
   endfunction

   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic unused_ok;
   assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

   // ---------------- write channel ----------------
   wstate_t           w_state_q, w_state_d;
   logic [ID_W-1:0]   w_id_q;
   logic [ADDR_W-1:0] w_addr_q;
   logic [7:0]        w_len_q;
   logic [2:0]        w_size_q;
   logic [1:0]        w_burst_q;
   logic              w_cfg_q;
   logic [8:0]        w_cnt_q;
   logic [1:0]        w_err_q, w_err_d;
   logic              w_beat, w_in_len, mem_we;
   logic [1:0]        w_beat_resp;

   assign w_beat   = s_axi_wvalid && s_axi_wready;
   assign w_in_len = w_cnt_q <= {1'b0, w_len_q};
   assign mem_we   = w_beat && w_in_len && !w_cfg_q && in_range(w_addr_q);

   // Per-beat response folded into the running worst-case burst response.
   always_comb begin
      w_beat_resp = OKAY;
      if (w_in_len && !in_range(w_addr_q)) w_beat_resp = DECERR;
      else if (w_cfg_q)                    w_beat_resp = SLVERR;
      if (s_axi_wlast && (w_cnt_q != {1'b0, w_len_q}))
         w_beat_resp = worst(w_beat_resp, SLVERR);
      w_err_d = worst(w_err_q, w_beat_resp);
   end

   // Write FSM state register.
   always_ff @(posedge mig_ui_clk) begin
      if (mig_ui_rst) w_state_q <= W_IDLE;
      else            w_state_q <= w_state_d;
   end

   // Write FSM next state.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (s_axi_awvalid)              w_state_d = W_DATA;
         W_DATA:  if (s_axi_wvalid && s_axi_wlast) w_state_d = W_RESP;
         W_RESP:  if (s_axi_bready)               w_state_d = W_IDLE;
         default:                                 w_state_d = W_IDLE;
      endcase
   end

   // Write channel outputs; everything is forced low while in reset.
   always_comb begin
      s_axi_awready = !mig_ui_rst && (w_state_q == W_IDLE);
      s_axi_wready  = !mig_ui_rst && (w_state_q == W_DATA);
      s_axi_bvalid  = !mig_ui_rst && (w_state_q == W_RESP);
      s_axi_bid     = s_axi_bvalid ? w_id_q  : '0;
      s_axi_bresp   = s_axi_bvalid ? w_err_q : OKAY;
   end

   // Write request latch, beat counter and address stepping.
   always_ff @(posedge mig_ui_clk) begin
      if (mig_ui_rst) begin
         w_id_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_size_q <= '0;
         w_burst_q <= '0; w_cfg_q <= 1'b0; w_cnt_q <= '0; w_err_q <= OKAY;
      end else if (s_axi_awvalid && s_axi_awready) begin
         w_id_q    <= s_axi_awid;
         w_addr_q  <= s_axi_awaddr;
         w_len_q   <= s_axi_awlen;
         w_size_q  <= s_axi_awsize;
         w_burst_q <= s_axi_awburst;
         w_cfg_q   <= cfg_err(s_axi_awsize, s_axi_awburst, s_axi_awlen);
         w_cnt_q   <= '0;
         w_err_q   <= OKAY;
      end else if (w_beat) begin
         w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
         w_cnt_q  <= w_cnt_q + {8'd0, (w_cnt_q != 9'h1FF)};
         w_err_q  <= w_err_d;
      end
   end

   // ---------------- RAM ----------------
   logic [63:0] mem [MEM_WORDS];
   logic [63:0] ram_rdata_q;

   // Byte-enabled write port.
   always_ff @(posedge mig_ui_clk) begin
      if (mem_we)
         for (int b = 0; b < 8; b++)
            if (s_axi_wstrb[b]) mem[w_addr_q[IDX_W+2:3]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
   end

   // ---------------- read channel ----------------
   rstate_t           r_state_q, r_state_d;
   logic [ID_W-1:0]   r_id_q;
   logic [ADDR_W-1:0] r_addr_q;
   logic [7:0]        r_len_q;
   logic [2:0]        r_size_q;
   logic [1:0]        r_burst_q;
   logic              r_cfg_q;
   logic [7:0]        r_cnt_q;
   logic [1:0]        r_resp_q;
   logic              r_last;

   assign r_last = (r_cnt_q == r_len_q);

   // Read port: only sampled in R_FETCH so the beat stays stable under stall;
   // a same-cycle write to the word returns the pre-write contents.
   always_ff @(posedge mig_ui_clk) begin
      if (r_state_q == R_FETCH) ram_rdata_q <= mem[r_addr_q[IDX_W+2:3]];
   end

   // Read FSM state register.
   always_ff @(posedge mig_ui_clk) begin
      if (mig_ui_rst) r_state_q <= R_IDLE;
      else            r_state_q <= r_state_d;
   end

   // Read FSM next state.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (s_axi_arvalid) r_state_d = R_FETCH;
         R_FETCH:                    r_state_d = R_DATA;
         R_DATA:  if (s_axi_rready)  r_state_d = r_last ? R_IDLE : R_FETCH;
         default:                    r_state_d = R_IDLE;
      endcase
   end

   // Read channel outputs; error beats carry zero data.
   always_comb begin
      s_axi_arready = !mig_ui_rst && (r_state_q == R_IDLE);
      s_axi_rvalid  = !mig_ui_rst && (r_state_q == R_DATA);
      s_axi_rid     = s_axi_rvalid ? r_id_q   : '0;
      s_axi_rresp   = s_axi_rvalid ? r_resp_q : OKAY;
      s_axi_rlast   = s_axi_rvalid && r_last;
      s_axi_rdata   = (s_axi_rvalid && (r_resp_q == OKAY)) ? ram_rdata_q : 64'd0;
   end

   // Read request latch, per-beat response and address stepping.
   always_ff @(posedge mig_ui_clk) begin
      if (mig_ui_rst) begin
         r_id_q <= '0; r_addr_q <= '0; r_len_q <= '0; r_size_q <= '0;
         r_burst_q <= '0; r_cfg_q <= 1'b0; r_cnt_q <= '0; r_resp_q <= OKAY;
      end else if (s_axi_arvalid && s_axi_arready) begin
         r_id_q    <= s_axi_arid;
         r_addr_q  <= s_axi_araddr;
         r_len_q   <= s_axi_arlen;
         r_size_q  <= s_axi_arsize;
         r_burst_q <= s_axi_arburst;
         r_cfg_q   <= cfg_err(s_axi_arsize, s_axi_arburst, s_axi_arlen);
         r_cnt_q   <= '0;
      end else if (r_state_q == R_FETCH) begin
         r_resp_q <= !in_range(r_addr_q) ? DECERR : (r_cfg_q ? SLVERR : OKAY);
      end else if ((r_state_q == R_DATA) && s_axi_rready && !r_last) begin
         r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
         r_cnt_q  <= r_cnt_q + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: scenario tasks push expected
// B/R responses into scoreboard queues and compare them against what the DUT returns.
module tb_axi_mem_responder;

   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [29:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0, wstrb = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
   logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [63:0] wdata = '0, rdata;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .mig_ui_clk(clk), .mig_ui_rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
      .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
      .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
   b_exp_t exp_b[$];
   r_exp_t exp_r[$];

   int checks = 0, failures = 0, cyc = 0;
   bit tmo = 0;
   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [3:0]  ob_id;
   logic [1:0]  ob_resp;
   logic [3:0]  ro_id   [32];
   logic [63:0] ro_data [32];
   logic [1:0]  ro_resp [32];
   logic        ro_last [32];
   int          ro_cyc  [32];
   int          ro_n = 0, stall_beat = -1;
   bit          stall_stable;

   always @(posedge clk) cyc <= cyc + 1;

   // Drivers: entered at a negedge and leave at a negedge. They only drive and record.
   task automatic aw_send(input logic [3:0] id, input logic [29:0] a, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bu);
      int t = 0;
      awid = id; awaddr = a; awlen = ln; awsize = sz; awburst = bu; awvalid = 1;
      while (!awready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) tmo = 1;
      @(posedge clk); @(negedge clk); awvalid = 0;
   endtask

   task automatic w_beats(input int nb, input bit with_last);
      for (int i = 0; i < nb; i++) begin
         int t = 0;
         wdata = wd[i]; wstrb = ws[i]; wlast = with_last && (i == nb-1); wvalid = 1;
         while (!wready && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) tmo = 1;
         @(posedge clk); @(negedge clk);
      end
      wvalid = 0; wlast = 0;
   endtask

   task automatic b_recv();
      int t = 0;
      bready = 1;
      while (!bvalid && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) tmo = 1;
      ob_id = bid; ob_resp = bresp;
      @(posedge clk); @(negedge clk); bready = 0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [29:0] a, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bu);
      int t = 0;
      arid = id; araddr = a; arlen = ln; arsize = sz; arburst = bu; arvalid = 1;
      while (!arready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) tmo = 1;
      @(posedge clk); @(negedge clk); arvalid = 0;
   endtask

   task automatic r_recv(input int maxb);
      bit done = 0;
      ro_n = 0; rready = 1; stall_stable = 1;
      while (!done) begin
         int t = 0;
         while (!rvalid && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) begin tmo = 1; done = 1; end
         else begin
            ro_cyc[ro_n] = cyc;
            if (ro_n == stall_beat) begin
               logic [63:0] d0; logic [3:0] i0;
               d0 = rdata; i0 = rid; rready = 0;
               repeat (5) begin
                  @(negedge clk);
                  if (rdata !== d0 || rid !== i0 || !rvalid) stall_stable = 0;
               end
               rready = 1;
            end
            ro_id[ro_n] = rid; ro_data[ro_n] = rdata; ro_resp[ro_n] = rresp; ro_last[ro_n] = rlast;
            done = rlast || (ro_n + 1 >= maxb);
            @(posedge clk); @(negedge clk);
            ro_n++;
         end
      end
   endtask

   // Simple helper: set wd/ws for n beats starting at value v (incrementing), full strobe.
   task automatic fill_w(input int n, input logic [63:0] v);
      for (int i = 0; i < n; i++) begin wd[i] = v + 64'(i); ws[i] = 8'hFF; end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata} !== '0) begin
         failures++; $display("FAIL reset_outputs: got nonzero outputs awr=%b wr=%b bv=%b arr=%b rv=%b rdata=%h",
                              awready, wready, bvalid, arready, rvalid, rdata);
      end
      rst = 0; #1;
      checks++;
      if (awready !== 1'b1 || arready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready: awready=%b arready=%b expected 1/1", awready, arready);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      b_exp_t eb; r_exp_t er;
      wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
      aw_send(4'd5, 30'h100, 8'd0, 3'd3, 2'b01);
      exp_b.push_back('{id: 4'd5, resp: 2'b00});
      w_beats(1, 1); b_recv();
      eb = exp_b.pop_front();
      checks++;
      if (ob_id !== eb.id || ob_resp !== eb.resp) begin
         failures++; $display("FAIL single_b: bid=%0d bresp=%b expected bid=%0d bresp=%b", ob_id, ob_resp, eb.id, eb.resp);
      end
      exp_r.push_back('{id: 4'd5, data: 64'hDEADBEEF_CAFEF00D, resp: 2'b00, last: 1'b1});
      ar_send(4'd5, 30'h100, 8'd0, 3'd3, 2'b01); r_recv(1);
      er = exp_r.pop_front();
      checks++;
      if (ro_n != 1 || ro_id[0] !== er.id || ro_data[0] !== er.data || ro_resp[0] !== er.resp || ro_last[0] !== er.last) begin
         failures++; $display("FAIL single_r: n=%0d rid=%0d rdata=%h rresp=%b rlast=%b expected rid=%0d rdata=%h rresp=%b rlast=%b",
                              ro_n, ro_id[0], ro_data[0], ro_resp[0], ro_last[0], er.id, er.data, er.resp, er.last);
      end
      checks++;
      if (tmo) begin failures++; $display("FAIL single_timeout: handshake timed out, expected completion"); end
      tmo = 0;
   endtask

   task automatic test_incr();
      b_exp_t eb; r_exp_t er;
      fill_w(4, 64'd1);
      aw_send(4'd2, 30'h200, 8'd3, 3'd3, 2'b01);
      exp_b.push_back('{id: 4'd2, resp: 2'b00});
      w_beats(4, 1); b_recv();
      eb = exp_b.pop_front();
      checks++;
      if (ob_id !== eb.id || ob_resp !== eb.resp) begin
         failures++; $display("FAIL incr_b: bid=%0d bresp=%b expected bid=%0d bresp=%b", ob_id, ob_resp, eb.id, eb.resp);
      end
      for (int i = 0; i < 4; i++) exp_r.push_back('{id: 4'd3, data: 64'(i+1), resp: 2'b00, last: (i == 3)});
      ar_send(4'd3, 30'h200, 8'd3, 3'd3, 2'b01); r_recv(8);
      checks++;
      if (ro_n != 4) begin failures++; $display("FAIL incr_count: beats=%0d expected 4", ro_n); end
      for (int i = 0; i < ro_n && exp_r.size() > 0; i++) begin
         er = exp_r.pop_front();
         checks++;
         if (ro_id[i] !== er.id || ro_data[i] !== er.data || ro_resp[i] !== er.resp || ro_last[i] !== er.last) begin
            failures++; $display("FAIL incr_r%0d: rid=%0d rdata=%h rresp=%b rlast=%b expected rid=%0d rdata=%h rresp=%b rlast=%b",
                                 i, ro_id[i], ro_data[i], ro_resp[i], ro_last[i], er.id, er.data, er.resp, er.last);
         end
         if (i > 0) begin
            checks++;
            if (ro_cyc[i] - ro_cyc[i-1] != 2) begin
               failures++; $display("FAIL incr_spacing%0d: gap=%0d cycles expected 2", i, ro_cyc[i] - ro_cyc[i-1]);
            end
         end
      end
      exp_r.delete();
   endtask

   task automatic test_wrap();
      r_exp_t er;
      logic [63:0] seq [4];
      seq[0] = 64'd4; seq[1] = 64'd1; seq[2] = 64'd2; seq[3] = 64'd3;
      for (int i = 0; i < 4; i++) exp_r.push_back('{id: 4'd7, data: seq[i], resp: 2'b00, last: (i == 3)});
      ar_send(4'd7, 30'h218, 8'd3, 3'd3, 2'b10); r_recv(8);
      checks++;
      if (ro_n != 4) begin failures++; $display("FAIL wrap_count: beats=%0d expected 4", ro_n); end
      for (int i = 0; i < ro_n && exp_r.size() > 0; i++) begin
         er = exp_r.pop_front();
         checks++;
         if (ro_data[i] !== er.data || ro_resp[i] !== er.resp || ro_last[i] !== er.last || ro_id[i] !== er.id) begin
            failures++; $display("FAIL wrap_r%0d: rdata=%h rresp=%b rlast=%b expected rdata=%h rresp=%b rlast=%b",
                                 i, ro_data[i], ro_resp[i], ro_last[i], er.data, er.resp, er.last);
         end
      end
      exp_r.delete();
      for (int i = 0; i < 3; i++) exp_r.push_back('{id: 4'd8, data: 64'd0, resp: 2'b10, last: (i == 2)});
      ar_send(4'd8, 30'h218, 8'd2, 3'd3, 2'b10); r_recv(8);
      checks++;
      if (ro_n != 3) begin failures++; $display("FAIL wrap_bad_count: beats=%0d expected 3", ro_n); end
      for (int i = 0; i < ro_n && exp_r.size() > 0; i++) begin
         er = exp_r.pop_front();
         checks++;
         if (ro_data[i] !== er.data || ro_resp[i] !== er.resp || ro_last[i] !== er.last) begin
            failures++; $display("FAIL wrap_bad_r%0d: rdata=%h rresp=%b rlast=%b expected rdata=%h rresp=%b rlast=%b",
                                 i, ro_data[i], ro_resp[i], ro_last[i], er.data, er.resp, er.last);
         end
      end
      exp_r.delete();
   endtask

   task automatic test_strobe();
      r_exp_t er;
      wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'hFF;
      aw_send(4'd1, 30'h300, 8'd0, 3'd3, 2'b01); w_beats(1, 1); b_recv();
      wd[0] = 64'h11223344_55667788; ws[0] = 8'h0F;
      aw_send(4'd1, 30'h300, 8'd0, 3'd3, 2'b01); w_beats(1, 1); b_recv();
      exp_r.push_back('{id: 4'd1, data: 64'hFFFFFFFF_55667788, resp: 2'b00, last: 1'b1});
      ar_send(4'd1, 30'h300, 8'd0, 3'd3, 2'b01); r_recv(1);
      er = exp_r.pop_front();
      checks++;
      if (ro_data[0] !== er.data || ro_resp[0] !== er.resp) begin
         failures++; $display("FAIL strobe_r: rdata=%h rresp=%b expected rdata=%h rresp=%b", ro_data[0], ro_resp[0], er.data, er.resp);
      end
   endtask

   task automatic test_oob();
      b_exp_t eb; r_exp_t er;
      wd[0] = 64'hA5A5A5A5_A5A5A5A5; ws[0] = 8'hFF;
      aw_send(4'd4, 30'h0, 8'd0, 3'd3, 2'b01); w_beats(1, 1); b_recv();
      wd[0] = 64'h00000000_00001234;
      exp_b.push_back('{id: 4'd4, resp: 2'b11});
      aw_send(4'd4, 30'h10000, 8'd0, 3'd3, 2'b01); w_beats(1, 1); b_recv();
      eb = exp_b.pop_front();
      checks++;
      if (ob_id !== eb.id || ob_resp !== eb.resp) begin
         failures++; $display("FAIL oob_b: bid=%0d bresp=%b expected bid=%0d bresp=%b", ob_id, ob_resp, eb.id, eb.resp);
      end
      exp_r.push_back('{id: 4'd6, data: 64'd0, resp: 2'b11, last: 1'b1});
      ar_send(4'd6, 30'h10000, 8'd0, 3'd3, 2'b01); r_recv(1);
      er = exp_r.pop_front();
      checks++;
      if (ro_data[0] !== er.data || ro_resp[0] !== er.resp || ro_last[0] !== er.last) begin
         failures++; $display("FAIL oob_r: rdata=%h rresp=%b expected rdata=%h rresp=%b", ro_data[0], ro_resp[0], er.data, er.resp);
      end
      exp_r.push_back('{id: 4'd6, data: 64'hA5A5A5A5_A5A5A5A5, resp: 2'b00, last: 1'b1});
      ar_send(4'd6, 30'h0, 8'd0, 3'd3, 2'b01); r_recv(1);
      er = exp_r.pop_front();
      checks++;
      if (ro_data[0] !== er.data || ro_resp[0] !== er.resp) begin
         failures++; $display("FAIL oob_ram_unchanged: rdata=%h expected %h", ro_data[0], er.data);
      end
   endtask

   task automatic test_backpressure();
      r_exp_t er;
      stall_beat = 1;
      for (int i = 0; i < 4; i++) exp_r.push_back('{id: 4'd9, data: 64'(i+1), resp: 2'b00, last: (i == 3)});
      ar_send(4'd9, 30'h200, 8'd3, 3'd3, 2'b01); r_recv(8);
      stall_beat = -1;
      checks++;
      if (!stall_stable) begin failures++; $display("FAIL bp_stable: rdata/rid/rvalid changed during stall, expected stable"); end
      checks++;
      if (ro_n != 4) begin failures++; $display("FAIL bp_count: beats=%0d expected 4", ro_n); end
      for (int i = 0; i < ro_n && exp_r.size() > 0; i++) begin
         er = exp_r.pop_front();
         checks++;
         if (ro_id[i] !== er.id || ro_data[i] !== er.data || ro_last[i] !== er.last) begin
            failures++; $display("FAIL bp_r%0d: rid=%0d rdata=%h rlast=%b expected rid=%0d rdata=%h rlast=%b",
                                 i, ro_id[i], ro_data[i], ro_last[i], er.id, er.data, er.last);
         end
      end
      exp_r.delete();
   endtask

   task automatic test_reset_mid_burst();
      b_exp_t eb; r_exp_t er;
      bit seen_b = 0;
      fill_w(4, 64'h50);
      aw_send(4'd3, 30'h400, 8'd3, 3'd3, 2'b01);
      w_beats(2, 0);
      rst = 1; #1;
      checks++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
         failures++; $display("FAIL midrst_outputs: awr=%b wr=%b bv=%b arr=%b rv=%b expected all 0", awready, wready, bvalid, arready, rvalid);
      end
      @(negedge clk); rst = 0;
      bready = 1;
      repeat (10) begin @(negedge clk); if (bvalid) seen_b = 1; end
      bready = 0;
      checks++;
      if (seen_b) begin failures++; $display("FAIL midrst_no_b: bvalid seen=1 expected 0"); end
      wd[0] = 64'h77; ws[0] = 8'hFF;
      exp_b.push_back('{id: 4'd10, resp: 2'b00});
      aw_send(4'd10, 30'h400, 8'd0, 3'd3, 2'b01); w_beats(1, 1); b_recv();
      eb = exp_b.pop_front();
      checks++;
      if (ob_id !== eb.id || ob_resp !== eb.resp) begin
         failures++; $display("FAIL midrst_next_b: bid=%0d bresp=%b expected bid=%0d bresp=%b", ob_id, ob_resp, eb.id, eb.resp);
      end
      exp_r.push_back('{id: 4'd10, data: 64'h77, resp: 2'b00, last: 1'b1});
      ar_send(4'd10, 30'h400, 8'd0, 3'd3, 2'b01); r_recv(1);
      er = exp_r.pop_front();
      checks++;
      if (ro_data[0] !== er.data || ro_resp[0] !== er.resp) begin
         failures++; $display("FAIL midrst_read: rdata=%h rresp=%b expected rdata=%h rresp=%b", ro_data[0], ro_resp[0], er.data, er.resp);
      end
      checks++;
      if (tmo) begin failures++; $display("FAIL run_timeout: a handshake timed out, expected completion"); end
      tmo = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr();
      test_wrap();
      test_strobe();
      test_oob();
      test_backpressure();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
